// File: rtl/des_align_pkg.sv
// Shared types and default parameters for the framed serial aligner.
package des_align_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_FRAME_LEN = 4;
  localparam logic [7:0]  DEF_SYNC_WORD = 8'hA5;
  localparam int unsigned DEF_LOCK_CNT  = 3;
  localparam int unsigned DEF_MISS_CNT  = 3;
  localparam int unsigned ERRCNT_W      = 8;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/des_align_cnt.sv
// Bit/word position tracker; a clear anchors it just after a sync word's LSB.
module des_align_cnt
  import des_align_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_word_end_c,
  output logic o_sync_slot_c
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned FW = $clog2(FRAME_LEN);

  logic [BW-1:0] r_bit;
  logic [FW-1:0] r_word;
  logic          w_bit_wrap;
  logic          w_word_wrap;

  assign w_bit_wrap  = (r_bit == BW'(WIDTH - 1));
  assign w_word_wrap = (r_word == FW'(FRAME_LEN - 1));

  // After a clear the next sampled bit is the MSB of data word 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_bit  <= '0;
      r_word <= FW'(1);
    end else if (i_en) begin
      if (w_bit_wrap) begin
        r_bit  <= '0;
        r_word <= w_word_wrap ? '0 : r_word + FW'(1);
      end else begin
        r_bit <= r_bit + BW'(1);
      end
    end
  end

  assign o_word_end_c  = w_bit_wrap;
  assign o_sync_slot_c = w_bit_wrap && (r_word == '0);

endmodule

// File: rtl/des_align.sv
// Framed serial receiver: hunts for SYNC_WORD, verifies it, then emits aligned words.
// Define DES_ALIGN_ERRCNT_EN to add the saturating sync_err_cnt output.
module des_align
  import des_align_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      FRAME_LEN = DEF_FRAME_LEN,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(DEF_SYNC_WORD),
  parameter int unsigned      LOCK_CNT  = DEF_LOCK_CNT,
  parameter int unsigned      MISS_CNT  = DEF_MISS_CNT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             locked,
  output logic             sync_err
`ifdef DES_ALIGN_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] sync_err_cnt
`endif
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW = $clog2(MISS_CNT + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [GW-1:0]    r_good;
  logic [MW-1:0]    r_miss;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_locked;
  logic             r_err;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [GW-1:0]    w_good_nxt;
  logic [GW-1:0]    w_good_inc;
  logic [MW-1:0]    w_miss_nxt;
  logic [MW-1:0]    w_miss_inc;
  logic [WIDTH-1:0] w_dout_nxt;
  logic             w_valid_nxt;
  logic             w_err_nxt;
  logic             w_clear;
  logic             w_match;
  logic             w_word_end;
  logic             w_sync_slot;

  assign w_sr_nxt   = {r_sr[WIDTH-2:0], din};
  assign w_match    = (w_sr_nxt == SYNC_WORD);
  assign w_good_inc = r_good + GW'(1);
  assign w_miss_inc = r_miss + MW'(1);

  des_align_cnt #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FRAME_LEN)
  ) u_cnt (
    .clk           (clock),
    .rst_n         (reset_n),
    .i_clear       (w_clear),
    .i_en          (enable),
    .o_word_end_c  (w_word_end),
    .o_sync_slot_c (w_sync_slot)
  );

  // Next-state and output decode; nothing advances while enable is low.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    w_dout_nxt  = r_dout;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_clear     = 1'b0;
    if (enable) begin
      unique case (r_state)
        ST_HUNT: begin
          if (w_match) begin
            w_clear     = 1'b1;
            w_good_nxt  = GW'(1);
            w_miss_nxt  = '0;
            w_state_nxt = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (w_sync_slot) begin
            if (w_match) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc == GW'(LOCK_CNT)) begin
                w_miss_nxt  = '0;
                w_state_nxt = ST_LOCKED;
              end
            end else begin
              w_state_nxt = ST_HUNT;
            end
          end
        end
        ST_LOCKED: begin
          if (w_sync_slot) begin
            if (w_match) begin
              w_miss_nxt = '0;
            end else begin
              w_err_nxt  = 1'b1;
              w_miss_nxt = w_miss_inc;
              if (w_miss_inc == MW'(MISS_CNT)) begin
                w_state_nxt = ST_HUNT;
              end
            end
          end else if (w_word_end) begin
            w_dout_nxt  = w_sr_nxt;
            w_valid_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_HUNT;
      r_sr     <= '0;
      r_good   <= '0;
      r_miss   <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (enable) begin
        r_sr <= w_sr_nxt;
      end
      r_state  <= w_state_nxt;
      r_good   <= w_good_nxt;
      r_miss   <= w_miss_nxt;
      r_dout   <= w_dout_nxt;
      r_valid  <= w_valid_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
      r_err    <= w_err_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign locked     = r_locked;
  assign sync_err   = r_err;

`ifdef DES_ALIGN_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  // Saturating count of missed syncs; only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err_cnt <= '0;
    end else if (w_err_nxt && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
    end
  end

  assign sync_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_des_align.sv
// Self-checking bench for des_align against a bit-index based reference model.
// Build with DES_ALIGN_ERRCNT_EN defined to also exercise sync_err_cnt.
module tb_des_align;

  localparam int unsigned W    = 8;
  localparam int unsigned FL   = 4;
  localparam int unsigned LOCK = 3;
  localparam int unsigned MISS = 3;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic       din     = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       locked;
  logic       sync_err;
`ifdef DES_ALIGN_ERRCNT_EN
  logic [7:0] sync_err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  des_align #(
    .WIDTH     (W),
    .FRAME_LEN (FL),
    .SYNC_WORD (SYNC),
    .LOCK_CNT  (LOCK),
    .MISS_CNT  (MISS)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .sync_err   (sync_err)
`ifdef DES_ALIGN_ERRCNT_EN
    ,
    .sync_err_cnt (sync_err_cnt)
`endif
  );

  // Reference model: alignment expressed as distance (in sampled bits) from the anchoring sync.
  int unsigned m_k, m_anchor;
  int          m_mode;
  int          m_good, m_miss;
  logic [7:0]  m_win;
  logic [7:0]  exp_dout;
  logic        exp_valid, exp_locked, exp_err;
  int          exp_cnt;

  function automatic void model_reset();
    m_k = 0; m_anchor = 0; m_mode = 0; m_good = 0; m_miss = 0; m_win = '0;
    exp_dout = '0; exp_valid = 1'b0; exp_locked = 1'b0; exp_err = 1'b0; exp_cnt = 0;
  endfunction

  function automatic void model_step(input logic b, input logic en);
    int unsigned slot;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (!en) return;
    m_win = {m_win[6:0], b};
    m_k++;
    if (m_mode == 0) begin
      if (m_win == SYNC) begin
        m_anchor = m_k; m_good = 1; m_miss = 0;
        m_mode = (LOCK == 1) ? 2 : 1;
      end
    end else if ((m_k - m_anchor) % W == 0) begin
      slot = ((m_k - m_anchor) / W) % FL;
      if (m_mode == 1) begin
        if (slot == 0) begin
          if (m_win == SYNC) begin
            m_good++;
            if (m_good == int'(LOCK)) begin m_mode = 2; m_miss = 0; end
          end else begin
            m_mode = 0;
          end
        end
      end else if (slot != 0) begin
        exp_dout = m_win; exp_valid = 1'b1;
      end else if (m_win == SYNC) begin
        m_miss = 0;
      end else begin
        exp_err = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
        m_miss++;
        if (m_miss == int'(MISS)) m_mode = 0;
      end
    end
    exp_locked = (m_mode == 2);
  endfunction

  // Stimulus queues: one entry per clock (bit value, enable) plus the data words pushed.
  logic       q_b[$];
  logic       q_e[$];
  logic [7:0] q_d[$];

  function automatic void q_clear();
    q_b.delete(); q_e.delete(); q_d.delete();
  endfunction

  function automatic void push_bits(input logic b, input int n, input logic en);
    for (int i = 0; i < n; i++) begin
      q_b.push_back(en ? b : 1'($urandom_range(0, 1)));
      q_e.push_back(en);
    end
  endfunction

  function automatic void push_word(input logic [7:0] w, input int gap_at, input int gap_len);
    for (int i = 7; i >= 0; i--) begin
      q_b.push_back(w[i]);
      q_e.push_back(1'b1);
      if (7 - i == gap_at) push_bits(1'b0, gap_len, 1'b0);
    end
  endfunction

  function automatic void push_frame(input logic [7:0] s, input logic [7:0] d1,
                                     input logic [7:0] d2, input logic [7:0] d3);
    push_word(s, -1, 0);
    push_word(d1, -1, 0); q_d.push_back(d1);
    push_word(d2, -1, 0); q_d.push_back(d2);
    push_word(d3, -1, 0); q_d.push_back(d3);
  endfunction

  task automatic tick(input logic b, input logic en);
    din = b;
    enable = en;
    model_step(b, en);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    din = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (dout !== 8'h00)     begin n_bad++; $display("FAIL reset_dout got %h want 00", dout); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    n_cmp++; if (locked !== 1'b0)     begin n_bad++; $display("FAIL reset_locked got %b want 0", locked); end
    n_cmp++; if (sync_err !== 1'b0)   begin n_bad++; $display("FAIL reset_err got %b want 0", sync_err); end
`ifdef DES_ALIGN_ERRCNT_EN
    n_cmp++; if (sync_err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", sync_err_cnt); end
`endif
  endtask

  task automatic test_clean_lock();
    int first_lock = -1;
    int errs = 0;
    logic [7:0] got[$];
    do_reset();
    q_clear();
    push_bits(1'b0, 0, 1'b1);
    for (int j = 0; j < 3; j++) begin q_b.push_back(1'($urandom_range(0, 1))); q_e.push_back(1'b1); end
    for (int f = 0; f < 3; f++) push_frame(SYNC, 8'h11, 8'h22, 8'h33);
    for (int f = 0; f < 4; f++)
      push_frame(SYNC, (f == 3) ? SYNC : 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < q_b.size(); i++) begin
      tick(q_b[i], q_e[i]);
      n_cmp++;
      if ({dout, dout_valid, locked, sync_err} !== {exp_dout, exp_valid, exp_locked, exp_err}) begin
        n_bad++;
        $display("FAIL clean_lock step %0d: got %h want %h", i,
                 {dout, dout_valid, locked, sync_err}, {exp_dout, exp_valid, exp_locked, exp_err});
      end
      if (locked && first_lock < 0) first_lock = i;
      if (sync_err) errs++;
      if (dout_valid) got.push_back(dout);
    end
    n_cmp++; if (first_lock != 74) begin n_bad++; $display("FAIL clean_lock_rise got step %0d want 74", first_lock); end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL clean_lock_errs got %0d want 0", errs); end
    n_cmp++; if (got.size() != q_d.size() - 6) begin n_bad++; $display("FAIL clean_lock_count got %0d want %0d", got.size(), q_d.size() - 6); end
    for (int i = 0; i < got.size() && i + 6 < q_d.size(); i++) begin
      n_cmp++;
      if (got[i] !== q_d[i + 6]) begin n_bad++; $display("FAIL clean_lock_word %0d got %h want %h", i, got[i], q_d[i + 6]); end
    end
  endtask

  task automatic test_false_sync();
    int split;
    int bad_valid = 0;
    int bad_lock = 0;
    do_reset();
    q_clear();
    push_bits(1'b0, 2, 1'b1);
    push_word(SYNC, -1, 0);
    for (int j = 0; j < 6; j++) push_word(8'h00, -1, 0);
    split = q_b.size();
    for (int f = 0; f < 3; f++) push_frame(SYNC, 8'h11, 8'h22, 8'h33);
    for (int i = 0; i < q_b.size(); i++) begin
      tick(q_b[i], q_e[i]);
      n_cmp++;
      if ({dout, dout_valid, locked, sync_err} !== {exp_dout, exp_valid, exp_locked, exp_err}) begin
        n_bad++;
        $display("FAIL false_sync step %0d: got %h want %h", i,
                 {dout, dout_valid, locked, sync_err}, {exp_dout, exp_valid, exp_locked, exp_err});
      end
      if (i < split && dout_valid) bad_valid++;
      if (i < split && locked) bad_lock++;
    end
    n_cmp++; if (bad_valid != 0) begin n_bad++; $display("FAIL false_sync_valid got %0d want 0", bad_valid); end
    n_cmp++; if (bad_lock != 0) begin n_bad++; $display("FAIL false_sync_locked got %0d want 0", bad_lock); end
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL false_sync_relock got %b want 1", locked); end
  endtask

  task automatic test_single_miss();
    int errs = 0;
    int drops = 0;
    int valids = 0;
    do_reset();
    q_clear();
    for (int f = 0; f < 3; f++) push_frame(SYNC, 8'h11, 8'h22, 8'h33);
    push_frame(8'hA4, 8'h11, 8'h22, 8'h33);
    push_frame(SYNC,  8'h11, 8'h22, 8'h33);
    push_frame(8'hA4, 8'($urandom), 8'($urandom), 8'($urandom));
    push_frame(8'hA4, 8'($urandom), 8'($urandom), 8'($urandom));
    push_frame(SYNC,  8'h11, 8'h22, 8'h33);
    for (int i = 0; i < q_b.size(); i++) begin
      tick(q_b[i], q_e[i]);
      n_cmp++;
      if ({dout, dout_valid, locked, sync_err} !== {exp_dout, exp_valid, exp_locked, exp_err}) begin
        n_bad++;
        $display("FAIL single_miss step %0d: got %h want %h", i,
                 {dout, dout_valid, locked, sync_err}, {exp_dout, exp_valid, exp_locked, exp_err});
      end
      if (sync_err) errs++;
      if (i >= 71 && !locked) drops++;
      if (dout_valid) valids++;
    end
    n_cmp++; if (errs != 3) begin n_bad++; $display("FAIL single_miss_errs got %0d want 3", errs); end
    n_cmp++; if (drops != 0) begin n_bad++; $display("FAIL single_miss_drops got %0d want 0", drops); end
    n_cmp++; if (valids != 18) begin n_bad++; $display("FAIL single_miss_valids got %0d want 18", valids); end
  endtask

  task automatic test_lock_loss();
    int errs = 0;
    int fall = -1;
    int late_valid = 0;
    logic [7:0] bad;
    do_reset();
    q_clear();
    for (int f = 0; f < 3; f++) push_frame(SYNC, 8'h11, 8'h22, 8'h33);
    for (int f = 0; f < 3; f++) begin
      bad = SYNC ^ 8'(1 << $urandom_range(0, 7));
      push_frame(bad, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int j = 0; j < 3 * 8; j++) begin void'(q_b.pop_back()); void'(q_e.pop_back()); end
    push_bits(1'b0, 40, 1'b1);
    for (int i = 0; i < q_b.size(); i++) begin
      tick(q_b[i], q_e[i]);
      n_cmp++;
      if ({dout, dout_valid, locked, sync_err} !== {exp_dout, exp_valid, exp_locked, exp_err}) begin
        n_bad++;
        $display("FAIL lock_loss step %0d: got %h want %h", i,
                 {dout, dout_valid, locked, sync_err}, {exp_dout, exp_valid, exp_locked, exp_err});
      end
      if (sync_err) errs++;
      if (i > 71 && !locked && fall < 0) fall = i;
      if (fall >= 0 && i > fall && dout_valid) late_valid++;
    end
    n_cmp++; if (errs != 3) begin n_bad++; $display("FAIL lock_loss_errs got %0d want 3", errs); end
    n_cmp++; if (fall != 167) begin n_bad++; $display("FAIL lock_loss_fall got step %0d want 167", fall); end
    n_cmp++; if (late_valid != 0) begin n_bad++; $display("FAIL lock_loss_valid got %0d want 0", late_valid); end
  endtask

  task automatic test_enable_gap();
    int errs = 0;
    logic [7:0] got[$];
    logic [7:0] d;
    do_reset();
    q_clear();
    for (int f = 0; f < 3; f++) push_frame(SYNC, 8'h11, 8'h22, 8'h33);
    for (int f = 0; f < 3; f++) begin
      push_word(SYNC, (f == 2) ? int'($urandom_range(0, 6)) : -1, 3);
      for (int w = 0; w < 3; w++) begin
        d = 8'($urandom);
        q_d.push_back(d);
        if (f == 0 && w == 1) push_word(d, 3, 5);
        else push_word(d, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1,
                       int'($urandom_range(1, 4)));
      end
    end
    for (int i = 0; i < q_b.size(); i++) begin
      tick(q_b[i], q_e[i]);
      n_cmp++;
      if ({dout, dout_valid, locked, sync_err} !== {exp_dout, exp_valid, exp_locked, exp_err}) begin
        n_bad++;
        $display("FAIL enable_gap step %0d: got %h want %h", i,
                 {dout, dout_valid, locked, sync_err}, {exp_dout, exp_valid, exp_locked, exp_err});
      end
      if (sync_err) errs++;
      if (dout_valid) got.push_back(dout);
    end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL enable_gap_errs got %0d want 0", errs); end
    n_cmp++; if (got.size() != q_d.size() - 6) begin n_bad++; $display("FAIL enable_gap_count got %0d want %0d", got.size(), q_d.size() - 6); end
    for (int i = 0; i < got.size() && i + 6 < q_d.size(); i++) begin
      n_cmp++;
      if (got[i] !== q_d[i + 6]) begin n_bad++; $display("FAIL enable_gap_word %0d got %h want %h", i, got[i], q_d[i + 6]); end
    end
  endtask

  task automatic test_reset_mid();
    int first_lock = -1;
    do_reset();
    q_clear();
    for (int f = 0; f < 3; f++) push_frame(SYNC, 8'h11, 8'h22, 8'h33);
    push_word(SYNC, -1, 0);
    push_word(8'h11, -1, 0);
    push_bits(1'b1, 4, 1'b1);
    for (int i = 0; i < q_b.size(); i++) tick(q_b[i], q_e[i]);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL reset_mid_pre got %b want 1", locked); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({dout, dout_valid, locked, sync_err} !== 11'h000) begin
      n_bad++; $display("FAIL reset_mid_async got %h want 000", {dout, dout_valid, locked, sync_err});
    end
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    q_clear();
    for (int f = 0; f < 4; f++) push_frame(SYNC, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < q_b.size(); i++) begin
      tick(q_b[i], q_e[i]);
      n_cmp++;
      if ({dout, dout_valid, locked, sync_err} !== {exp_dout, exp_valid, exp_locked, exp_err}) begin
        n_bad++;
        $display("FAIL reset_mid step %0d: got %h want %h", i,
                 {dout, dout_valid, locked, sync_err}, {exp_dout, exp_valid, exp_locked, exp_err});
      end
      if (locked && first_lock < 0) first_lock = i;
    end
    n_cmp++; if (first_lock != 71) begin n_bad++; $display("FAIL reset_mid_relock got step %0d want 71", first_lock); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    do_reset();
    q_clear();
    push_bits(1'b0, int'($urandom_range(0, 7)), 1'b1);
    for (int f = 0; f < 24; f++) begin
      s = ($urandom_range(0, 5) == 0) ? (SYNC ^ 8'(1 << $urandom_range(0, 7))) : SYNC;
      push_word(s, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1, int'($urandom_range(1, 4)));
      for (int w = 0; w < 3; w++)
        push_word(8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1,
                  int'($urandom_range(1, 4)));
    end
    for (int i = 0; i < q_b.size(); i++) begin
      tick(q_b[i], q_e[i]);
      n_cmp++;
      if ({dout, dout_valid, locked, sync_err} !== {exp_dout, exp_valid, exp_locked, exp_err}) begin
        n_bad++;
        $display("FAIL back_to_back step %0d: got %h want %h", i,
                 {dout, dout_valid, locked, sync_err}, {exp_dout, exp_valid, exp_locked, exp_err});
      end
    end
  endtask

`ifdef DES_ALIGN_ERRCNT_EN
  task automatic test_errcnt();
    do_reset();
    q_clear();
    for (int r = 0; r < 100; r++) begin
      for (int f = 0; f < 3; f++) push_frame(SYNC, 8'($urandom), 8'($urandom), 8'($urandom));
      for (int f = 0; f < 3; f++) push_frame(8'h5A, 8'h00, 8'h00, 8'h00);
    end
    for (int i = 0; i < q_b.size(); i++) begin
      tick(q_b[i], q_e[i]);
      n_cmp++;
      if ({sync_err_cnt, dout, dout_valid, locked, sync_err} !==
          {8'(exp_cnt), exp_dout, exp_valid, exp_locked, exp_err}) begin
        n_bad++;
        $display("FAIL errcnt step %0d: got %h want %h", i,
                 {sync_err_cnt, dout, dout_valid, locked, sync_err},
                 {8'(exp_cnt), exp_dout, exp_valid, exp_locked, exp_err});
      end
    end
    n_cmp++; if (sync_err_cnt !== 8'd255) begin n_bad++; $display("FAIL errcnt_sat got %0d want 255", sync_err_cnt); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_clean_lock();
    test_false_sync();
    test_single_miss();
    test_lock_loss();
    test_enable_gap();
    test_reset_mid();
    test_back_to_back();
`ifdef DES_ALIGN_ERRCNT_EN
    test_errcnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
